// File: rtl/wb_sram_responder.sv
// Wishbone responder mapping a fixed word-address window onto a
// 1-cycle-latency synchronous SRAM, with programmable wait states.
module wb_sram_responder #(
    parameter int          MEM_AW      = 8,
    parameter logic [23:0] BASE_ADDR   = 24'h000100,
    parameter int          WAIT_STATES = 0
) (
    input  logic              rst,
    input  logic              clk,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [23:0]       wbs_adr_i,
    input  logic [3:0]        wbs_be_i,
    input  logic [31:0]       wbs_dat_i,
    output logic [31:0]       wbs_dat_o,
    output logic              wbs_ack_o,
    output logic              wbs_err_o,
    output logic              mem_csb_o,
    output logic              mem_web_o,
    output logic [3:0]        mem_wmask_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [31:0]       mem_din_o,
    input  logic [31:0]       mem_dout_i
);

    typedef enum logic [2:0] {IDLE, WAIT, ACCESS, RDATA, RESP} state_t;

    localparam logic [3:0] WS = WAIT_STATES[3:0];

    state_t            state, state_d;
    logic [3:0]        cnt, cnt_d;
    logic              ack_d, err_d, csb_d, web_d;
    logic [3:0]        wmask_d;
    logic [MEM_AW-1:0] addr_d;
    logic [31:0]       din_d, dat_d;
    logic              hit;

    assign hit = (wbs_adr_i[23:MEM_AW] == BASE_ADDR[23:MEM_AW]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            wbs_ack_o   <= 1'b0;
            wbs_err_o   <= 1'b0;
            wbs_dat_o   <= '0;
            mem_csb_o   <= 1'b1;
            mem_web_o   <= 1'b1;
            mem_wmask_o <= '0;
            mem_addr_o  <= '0;
            mem_din_o   <= '0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            wbs_ack_o   <= ack_d;
            wbs_err_o   <= err_d;
            wbs_dat_o   <= dat_d;
            mem_csb_o   <= csb_d;
            mem_web_o   <= web_d;
            mem_wmask_o <= wmask_d;
            mem_addr_o  <= addr_d;
            mem_din_o   <= din_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        ack_d   = wbs_ack_o;
        err_d   = wbs_err_o;
        dat_d   = wbs_dat_o;
        csb_d   = mem_csb_o;
        web_d   = mem_web_o;
        wmask_d = mem_wmask_o;
        addr_d  = mem_addr_o;
        din_d   = mem_din_o;
        unique case (state)
            IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    if (!hit) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        web_d   = ~wbs_we_i;
                        addr_d  = wbs_adr_i[MEM_AW-1:0];
                        wmask_d = wbs_be_i;
                        din_d   = wbs_dat_i;
                        if (WAIT_STATES == 0) begin
                            csb_d   = 1'b0;
                            state_d = ACCESS;
                        end else begin
                            cnt_d   = WS;
                            state_d = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                if (!wbs_cyc_i) begin
                    cnt_d   = '0;
                    web_d   = 1'b1;
                    state_d = IDLE;
                end else if (cnt == 4'd1) begin
                    cnt_d   = '0;
                    csb_d   = 1'b0;
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            ACCESS: begin
                // the SRAM op is committed; an abort here only drops the ack
                csb_d = 1'b1;
                web_d = 1'b1;
                if (!wbs_cyc_i) begin
                    state_d = IDLE;
                end else if (!mem_web_o) begin
                    ack_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    state_d = RDATA;
                end
            end
            RDATA: begin
                if (!wbs_cyc_i) begin
                    state_d = IDLE;
                end else begin
                    dat_d   = mem_dout_i;
                    ack_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                ack_d   = 1'b0;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb_sram_responder.sv
// Randomized bench for wb_sram_responder: two instances (0 and 2 wait
// states), each with an SRAM model, checked against a word-array reference.
module tb_wb_sram_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc [2];
    logic        stb [2];
    logic        we [2];
    logic [23:0] adr [2];
    logic [3:0]  be [2];
    logic [31:0] dat [2];
    logic [31:0] dat_o [2];
    logic        ack_o [2];
    logic        err_o [2];
    logic        csb [2];
    logic        web [2];
    logic [3:0]  wmask [2];
    logic [7:0]  maddr [2];
    logic [31:0] din [2];
    logic [31:0] dout [2];

    logic [31:0] sram [2][256];
    logic [31:0] refm [2][256];
    logic [31:0] last_rd [2];
    int          acc [2];
    int          ackc [2];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        wb_sram_responder #(
            .MEM_AW(8), .BASE_ADDR(24'h000100), .WAIT_STATES(2 * g)
        ) u_dut (
            .rst(rst), .clk(clk),
            .wbs_cyc_i(cyc[g]), .wbs_stb_i(stb[g]), .wbs_we_i(we[g]),
            .wbs_adr_i(adr[g]), .wbs_be_i(be[g]), .wbs_dat_i(dat[g]),
            .wbs_dat_o(dat_o[g]), .wbs_ack_o(ack_o[g]), .wbs_err_o(err_o[g]),
            .mem_csb_o(csb[g]), .mem_web_o(web[g]), .mem_wmask_o(wmask[g]),
            .mem_addr_o(maddr[g]), .mem_din_o(din[g]), .mem_dout_i(dout[g])
        );
    end

    // SRAM macro behaviour: byte-masked write, registered read
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!csb[i]) begin
                if (!web[i]) begin
                    for (int b = 0; b < 4; b++)
                        if (wmask[i][b]) sram[i][maddr[i]][8*b +: 8] <= din[i][8*b +: 8];
                end else begin
                    dout[i] <= sram[i][maddr[i]];
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!csb[i]) acc[i] <= acc[i] + 1;
            if (ack_o[i]) ackc[i] <= ackc[i] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input int k);
        check("rst_dat", dat_o[k], 32'h0);
        check("rst_ack", 32'(ack_o[k]), 32'h0);
        check("rst_err", 32'(err_o[k]), 32'h0);
        check("rst_csb", 32'(csb[k]), 32'h1);
        check("rst_web", 32'(web[k]), 32'h1);
        check("rst_wmask", 32'(wmask[k]), 32'h0);
        check("rst_addr", 32'(maddr[k]), 32'h0);
        check("rst_din", din[k], 32'h0);
    endtask

    task automatic xfer(input int k, input bit w, input logic [23:0] a,
                        input logic [3:0] b, input logic [31:0] d);
        bit hit, done;
        int n, a0, lat;
        hit = (a[23:8] == 16'h0001);
        @(negedge clk);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w;
        adr[k] = a; be[k] = b; dat[k] = d;
        a0 = acc[k];
        n = 0; done = 0;
        @(posedge clk);
        while (!done && n < 40) begin
            @(negedge clk);
            stb[k] = 1'b0;
            if (ack_o[k] || err_o[k]) done = 1;
            else begin
                @(posedge clk);
                n++;
            end
        end
        if (!done) check("timeout", 32'h0, 32'h1);
        lat = !hit ? 0 : (w ? 1 + 2 * k : 2 + 2 * k);
        if (hit && w) begin
            for (int i = 0; i < 4; i++)
                if (b[i]) refm[k][a[7:0]][8*i +: 8] = d[8*i +: 8];
        end
        if (hit && !w) last_rd[k] = refm[k][a[7:0]];
        check("latency", 32'(n), 32'(lat));
        check("ack", 32'(ack_o[k]), 32'(hit));
        check("err", 32'(err_o[k]), 32'(!hit));
        check("rdata", dat_o[k], last_rd[k]);
        @(negedge clk);
        cyc[k] = 1'b0;
        check("one_pulse", 32'(ack_o[k] | err_o[k]), 32'h0);
        check("accesses", 32'(acc[k] - a0), 32'(hit));
    endtask

    initial begin
        int a0, c0, beat, t;
        for (int k = 0; k < 2; k++) begin
            cyc[k] = 0; stb[k] = 0; we[k] = 0; adr[k] = 0;
            be[k] = 0; dat[k] = 0; last_rd[k] = 0; acc[k] = 0; ackc[k] = 0;
            for (int i = 0; i < 256; i++) begin
                sram[k][i] = 32'(i * 32'h01010101);
                refm[k][i] = 32'(i * 32'h01010101);
            end
        end
        #12;
        chk_reset(0);
        chk_reset(1);
        @(negedge clk);
        rst = 1'b0;

        // directed: full write, read back, partial write, miss
        xfer(0, 1, 24'h000105, 4'hF, 32'h11223344);
        check("wmask_full", 32'(wmask[0]), 32'hF);
        xfer(0, 0, 24'h000105, 4'h0, 32'h0);
        check("rd_full", dat_o[0], 32'h11223344);
        xfer(0, 1, 24'h000105, 4'b1100, 32'hAABBCCDD);
        check("wmask_part", 32'(wmask[0]), 32'hC);
        xfer(0, 0, 24'h000105, 4'h0, 32'h0);
        check("rd_part", dat_o[0], 32'hAABB3344);
        xfer(0, 0, 24'h000200, 4'hF, 32'h0);
        xfer(0, 1, 24'h000106, 4'h0, 32'hFFFFFFFF);
        xfer(0, 0, 24'h000106, 4'hF, 32'h0);
        xfer(1, 0, 24'h000100, 4'hF, 32'h0);
        xfer(0, 0, 24'h000100, 4'hF, 32'h0);

        // burst: stb held high across four writes
        a0 = acc[0]; c0 = ackc[0];
        @(negedge clk);
        cyc[0] = 1; stb[0] = 1; we[0] = 1; be[0] = 4'hF;
        adr[0] = 24'h000110; dat[0] = 32'd1;
        beat = 0; t = 0;
        while (beat < 4 && t < 60) begin
            @(negedge clk);
            t++;
            if (ack_o[0]) begin
                beat++;
                if (beat < 4) begin
                    adr[0] = 24'h000110 + 24'(beat);
                    dat[0] = 32'(beat + 1);
                end else stb[0] = 0;
            end
        end
        @(negedge clk);
        cyc[0] = 0;
        repeat (3) @(negedge clk);
        check("burst_acks", 32'(ackc[0] - c0), 32'd4);
        check("burst_acc", 32'(acc[0] - a0), 32'd4);
        for (int i = 0; i < 4; i++) refm[0][8'h10 + 8'(i)] = 32'(i + 1);
        for (int i = 0; i < 4; i++) begin
            xfer(0, 0, 24'h000110 + 24'(i), 4'hF, 32'h0);
            check("burst_rd", dat_o[0], 32'(i + 1));
        end

        // abort during wait states
        a0 = acc[1]; c0 = ackc[1];
        @(negedge clk);
        cyc[1] = 1; stb[1] = 1; we[1] = 1; adr[1] = 24'h000101;
        be[1] = 4'hF; dat[1] = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        cyc[1] = 0; stb[1] = 0;
        repeat (6) @(negedge clk);
        check("abort_acc", 32'(acc[1] - a0), 32'h0);
        check("abort_ack", 32'(ackc[1] - c0), 32'h0);
        xfer(1, 0, 24'h000101, 4'hF, 32'h0);

        // reset while in RDATA
        @(negedge clk);
        cyc[0] = 1; stb[0] = 1; we[0] = 0; adr[0] = 24'h000105;
        @(posedge clk);
        @(negedge clk);
        stb[0] = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset(0);
        @(negedge clk);
        rst = 1'b0; cyc[0] = 0;
        last_rd[0] = 0; last_rd[1] = 0;
        xfer(0, 0, 24'h000105, 4'hF, 32'h0);

        // randomized traffic
        for (int i = 0; i < 80; i++) begin
            int k;
            logic [23:0] a;
            k = int'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) a = 24'($urandom);
            else a = {16'h0001, 8'($urandom_range(0, 31))};
            xfer(k, 1'($urandom), a, 4'($urandom), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
